// File: rtl/pulse_cmd_ctrl.sv
// rtl/pulse_cmd_ctrl.sv - button/pulse to FIFO write/read strobe controller with occupancy and sticky errors
// Optional auto-repeat of a held button is compiled in with `define PULSE_CMD_REPEAT_EN.
module pulse_cmd_ctrl #(
  parameter int DEPTH      = 64,
  parameter int REPEAT_DLY = 100,
  parameter int REPEAT_PER = 20
) (
  input  logic       clk_200H,
  input  logic       rst,
  input  logic       pulse_in,
  input  logic       sel_wr,
  input  logic       sel_rd,
  input  logic       fifo_full,
  input  logic       fifo_empty,
  output logic       wr_en,
  output logic       rd_en,
  output logic [6:0] occupancy,
  output logic       err_overflow,
  output logic       err_underflow,
  output logic       err_conflict
);

  // occupancy is a fixed 7-bit port, and the repeat counter relies on both timings being at least 1
  if (DEPTH < 1 || DEPTH > 127 || REPEAT_DLY < 1 || REPEAT_PER < 1) begin : g_cfg_check
    $error("pulse_cmd_ctrl: unsupported DEPTH/REPEAT_DLY/REPEAT_PER");
  end

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_HOLD   = 2'd1,
    S_REPEAT = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_next_state;
  logic       r_wr_en;
  logic       r_rd_en;
  logic [6:0] r_occ;
  logic       r_ovf;
  logic       r_udf;
  logic       r_cnf;

  logic       w_single;
  logic       w_issue_wr;
  logic       w_issue_rd;
  logic       w_set_cnf;
  logic       w_wr_ok;
  logic       w_rd_ok;

`ifdef PULSE_CMD_REPEAT_EN
  localparam int CMAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
  localparam int CW   = $clog2(CMAX + 2);

  logic          r_cmd_wr;
  logic          r_rep_arm;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_same;
`endif

  always_comb begin
    w_next_state = r_state;
    w_issue_wr   = 1'b0;
    w_issue_rd   = 1'b0;
    w_set_cnf    = 1'b0;
    w_single     = sel_wr ^ sel_rd;
`ifdef PULSE_CMD_REPEAT_EN
    // the repeat only continues while the very button that started it stays the only one pressed
    w_same    = r_rep_arm && w_single && (sel_wr == r_cmd_wr);
    w_cnt_nxt = r_cnt;
`endif
    case (r_state)
      S_IDLE: begin
        if (pulse_in && sel_wr && sel_rd) begin
          w_set_cnf    = 1'b1;
          w_next_state = S_HOLD;
        end else if (pulse_in && w_single) begin
          w_issue_wr   = sel_wr;
          w_issue_rd   = sel_rd;
          w_next_state = S_HOLD;
`ifdef PULSE_CMD_REPEAT_EN
          w_cnt_nxt    = CW'(1);
`endif
        end
      end
      S_HOLD: begin
        if (!sel_wr && !sel_rd) begin
          w_next_state = S_IDLE;
        end
`ifdef PULSE_CMD_REPEAT_EN
        else if (!w_same) begin
          w_cnt_nxt = '0;
        end else if (r_cnt >= CW'(REPEAT_DLY)) begin
          w_issue_wr   = r_cmd_wr;
          w_issue_rd   = !r_cmd_wr;
          w_cnt_nxt    = CW'(1);
          w_next_state = S_REPEAT;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
`endif
      end
`ifdef PULSE_CMD_REPEAT_EN
      S_REPEAT: begin
        if (!w_same) begin
          w_next_state = S_IDLE;
        end else if (r_cnt >= CW'(REPEAT_PER)) begin
          w_issue_wr = r_cmd_wr;
          w_issue_rd = !r_cmd_wr;
          w_cnt_nxt  = CW'(1);
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
`endif
      default: w_next_state = S_IDLE;
    endcase
    w_wr_ok = w_issue_wr && !fifo_full && (r_occ < 7'(DEPTH));
    w_rd_ok = w_issue_rd && !fifo_empty && (r_occ != 7'd0);
  end

  always_ff @(posedge clk_200H) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_wr_en <= 1'b0;
      r_rd_en <= 1'b0;
      r_occ   <= 7'd0;
      r_ovf   <= 1'b0;
      r_udf   <= 1'b0;
      r_cnf   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_wr_en <= w_wr_ok;
      r_rd_en <= w_rd_ok;
      // the count follows the strobe by one cycle and saturates at both ends
      if (r_wr_en && (r_occ != 7'(DEPTH))) begin
        r_occ <= r_occ + 7'd1;
      end else if (r_rd_en && (r_occ != 7'd0)) begin
        r_occ <= r_occ - 7'd1;
      end
      if (w_issue_wr && !w_wr_ok) r_ovf <= 1'b1;
      if (w_issue_rd && !w_rd_ok) r_udf <= 1'b1;
      if (w_set_cnf)              r_cnf <= 1'b1;
    end
  end

`ifdef PULSE_CMD_REPEAT_EN
  always_ff @(posedge clk_200H) begin
    if (rst) begin
      r_cmd_wr  <= 1'b0;
      r_rep_arm <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
      if (r_state == S_IDLE && pulse_in && w_single) begin
        r_cmd_wr  <= sel_wr;
        r_rep_arm <= 1'b1;
      end else if (w_set_cnf) begin
        r_rep_arm <= 1'b0;
      end
    end
  end
`endif

  assign wr_en         = r_wr_en;
  assign rd_en         = r_rd_en;
  assign occupancy     = r_occ;
  assign err_overflow  = r_ovf;
  assign err_underflow = r_udf;
  assign err_conflict  = r_cnf;

endmodule

// File: tb/tb_pulse_cmd_ctrl.sv
// tb/tb_pulse_cmd_ctrl.sv - self-checking bench for pulse_cmd_ctrl with a command-level reference model
module tb_pulse_cmd_ctrl;
  localparam int DEPTH      = 64;
  localparam int REPEAT_DLY = 100;
  localparam int REPEAT_PER = 20;

  logic       clk_200H = 1'b0;
  logic       rst = 1'b1;
  logic       pulse_in = 1'b0;
  logic       sel_wr = 1'b0;
  logic       sel_rd = 1'b0;
  logic       fifo_full = 1'b0;
  logic       fifo_empty = 1'b1;
  logic       wr_en;
  logic       rd_en;
  logic [6:0] occupancy;
  logic       err_overflow;
  logic       err_underflow;
  logic       err_conflict;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  int m_occ;
  bit m_ovf, m_udf, m_cnf;

  pulse_cmd_ctrl #(.DEPTH(DEPTH), .REPEAT_DLY(REPEAT_DLY), .REPEAT_PER(REPEAT_PER)) dut (
    .clk_200H(clk_200H), .rst(rst), .pulse_in(pulse_in), .sel_wr(sel_wr), .sel_rd(sel_rd),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .wr_en(wr_en), .rd_en(rd_en),
    .occupancy(occupancy), .err_overflow(err_overflow), .err_underflow(err_underflow),
    .err_conflict(err_conflict)
  );

  always #5 clk_200H = ~clk_200H;

  task automatic tick();
    @(posedge clk_200H);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; pulse_in = 1'b0; sel_wr = 1'b0; sel_rd = 1'b0;
    fifo_full = 1'b0; fifo_empty = 1'b1;
    tick();
    rst = 1'b0;
    m_occ = 0; m_ovf = 0; m_udf = 0; m_cnf = 0;
  endtask

  task automatic release_all();
    pulse_in = 1'b0; sel_wr = 1'b0; sel_rd = 1'b0;
    tick();
    tick();
  endtask

  task automatic write_once(output bit strobed);
    fifo_full = 1'b0;
    pulse_in = 1'b1; sel_wr = 1'b1; sel_rd = 1'b0;
    tick();
    strobed = wr_en;
    pulse_in = 1'b0;
    tick();
    release_all();
  endtask

  task automatic test_reset();
    rst = 1'b1; pulse_in = 1'b1; sel_wr = 1'b1;
    tick();
    tick();
    n_cmp++; if ({wr_en, rd_en} !== 2'b00) begin n_err++; $display("FAIL reset_strobes: got %b want 00", {wr_en, rd_en}); end
    n_cmp++; if (occupancy !== 7'd0) begin n_err++; $display("FAIL reset_occ: got %0d want 0", occupancy); end
    n_cmp++; if ({err_overflow, err_underflow, err_conflict} !== 3'b000) begin
      n_err++; $display("FAIL reset_flags: got %b want 000", {err_overflow, err_underflow, err_conflict}); end
    pulse_in = 1'b0; sel_wr = 1'b0;
  endtask

  task automatic test_single_write();
    do_reset();
    for (int c = 0; c < 9; c++) tick();
    fifo_full = 1'b0;
    pulse_in = 1'b1; sel_wr = 1'b1;
    tick();
    n_cmp++; if (wr_en !== 1'b1) begin n_err++; $display("FAIL single_wr_n1: got %b want 1", wr_en); end
    n_cmp++; if (occupancy !== 7'd0) begin n_err++; $display("FAIL single_occ_n1: got %0d want 0", occupancy); end
    pulse_in = 1'b0;
    tick();
    n_cmp++; if (wr_en !== 1'b0) begin n_err++; $display("FAIL single_wr_n2: got %b want 0", wr_en); end
    n_cmp++; if (occupancy !== 7'd1) begin n_err++; $display("FAIL single_occ_n2: got %0d want 1", occupancy); end
    release_all();
  endtask

  task automatic test_idle_no_select();
    do_reset();
    pulse_in = 1'b1;
    tick();
    n_cmp++; if ({wr_en, rd_en} !== 2'b00) begin n_err++; $display("FAIL nosel_strobes: got %b want 00", {wr_en, rd_en}); end
    sel_wr = 1'b1;
    tick();
    n_cmp++; if (wr_en !== 1'b1) begin n_err++; $display("FAIL nosel_then_wr: got %b want 1", wr_en); end
    release_all();
  endtask

  task automatic test_overflow();
    int cnt = 0;
    bit s;
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      write_once(s);
      if (s) cnt++;
    end
    n_cmp++; if (cnt !== DEPTH) begin n_err++; $display("FAIL ovf_fill_strobes: got %0d want %0d", cnt, DEPTH); end
    n_cmp++; if (occupancy !== 7'(DEPTH)) begin n_err++; $display("FAIL ovf_fill_occ: got %0d want %0d", occupancy, DEPTH); end
    fifo_full = 1'b1;
    pulse_in = 1'b1; sel_wr = 1'b1;
    tick();
    n_cmp++; if (wr_en !== 1'b0) begin n_err++; $display("FAIL ovf_wr_full: got %b want 0", wr_en); end
    pulse_in = 1'b0;
    tick();
    n_cmp++; if (occupancy !== 7'(DEPTH)) begin n_err++; $display("FAIL ovf_occ: got %0d want %0d", occupancy, DEPTH); end
    n_cmp++; if (err_overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag: got %b want 1", err_overflow); end
    release_all();
    fifo_full = 1'b0;
    pulse_in = 1'b1; sel_wr = 1'b1;
    tick();
    n_cmp++; if (wr_en !== 1'b0) begin n_err++; $display("FAIL ovf_wr_occ_gate: got %b want 0", wr_en); end
    release_all();
    fifo_empty = 1'b0;
    pulse_in = 1'b1; sel_rd = 1'b1;
    tick();
    n_cmp++; if (rd_en !== 1'b1) begin n_err++; $display("FAIL ovf_rd_after: got %b want 1", rd_en); end
    pulse_in = 1'b0;
    tick();
    n_cmp++; if (occupancy !== 7'(DEPTH - 1)) begin n_err++; $display("FAIL ovf_rd_occ: got %0d want %0d", occupancy, DEPTH - 1); end
    release_all();
  endtask

  task automatic test_underflow();
    do_reset();
    fifo_empty = 1'b1;
    pulse_in = 1'b1; sel_rd = 1'b1;
    tick();
    n_cmp++; if (rd_en !== 1'b0) begin n_err++; $display("FAIL udf_rd: got %b want 0", rd_en); end
    pulse_in = 1'b0;
    tick();
    n_cmp++; if (err_underflow !== 1'b1) begin n_err++; $display("FAIL udf_flag: got %b want 1", err_underflow); end
    n_cmp++; if (occupancy !== 7'd0) begin n_err++; $display("FAIL udf_occ: got %0d want 0", occupancy); end
    release_all();
    pulse_in = 1'b1; sel_wr = 1'b1;
    tick();
    n_cmp++; if (wr_en !== 1'b1) begin n_err++; $display("FAIL udf_then_wr: got %b want 1", wr_en); end
    release_all();
  endtask

  task automatic test_conflict();
    do_reset();
    fifo_empty = 1'b0;
    pulse_in = 1'b1; sel_wr = 1'b1; sel_rd = 1'b1;
    tick();
    n_cmp++; if ({wr_en, rd_en} !== 2'b00) begin n_err++; $display("FAIL cnf_strobes: got %b want 00", {wr_en, rd_en}); end
    pulse_in = 1'b0;
    tick();
    n_cmp++; if (err_conflict !== 1'b1) begin n_err++; $display("FAIL cnf_flag: got %b want 1", err_conflict); end
    pulse_in = 1'b1;
    tick();
    n_cmp++; if ({wr_en, rd_en} !== 2'b00) begin n_err++; $display("FAIL cnf_second_pulse: got %b want 00", {wr_en, rd_en}); end
    sel_rd = 1'b0;
    tick();
    n_cmp++; if (wr_en !== 1'b0) begin n_err++; $display("FAIL cnf_hold_wr: got %b want 0", wr_en); end
    release_all();
    pulse_in = 1'b1; sel_wr = 1'b1;
    tick();
    n_cmp++; if (wr_en !== 1'b1) begin n_err++; $display("FAIL cnf_then_wr: got %b want 1", wr_en); end
    release_all();
  endtask

  task automatic test_repeat();
    int got_q[$];
    int exp_q[$];
    do_reset();
    fifo_full = 1'b0;
    exp_q.push_back(1);
`ifdef PULSE_CMD_REPEAT_EN
    for (int c = REPEAT_DLY; c < 200; c += REPEAT_PER) exp_q.push_back(c + 1);
`endif
    for (int k = 0; k < 210; k++) begin
      pulse_in = (k == 0);
      sel_wr   = (k < 200);
      tick();
      if (wr_en === 1'b1) got_q.push_back(k + 1);
    end
    n_cmp++; if (got_q.size() !== exp_q.size()) begin
      n_err++; $display("FAIL repeat_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++; if (got_q[i] !== exp_q[i]) begin
        n_err++; $display("FAIL repeat_cycle[%0d]: got %0d want %0d", i, got_q[i], exp_q[i]); end
    end
    release_all();
  endtask

  task automatic test_reset_priority();
    bit s;
    do_reset();
    for (int i = 0; i < 5; i++) write_once(s);
    fifo_empty = 1'b1;
    pulse_in = 1'b1; sel_wr = 1'b1; sel_rd = 1'b1;
    tick();
    release_all();
    fifo_empty = 1'b1;
    pulse_in = 1'b1; sel_rd = 1'b1;
    tick();
    release_all();
    n_cmp++; if (occupancy !== 7'd5) begin n_err++; $display("FAIL rstpri_pre_occ: got %0d want 5", occupancy); end
    rst = 1'b1; pulse_in = 1'b1; sel_wr = 1'b1;
    tick();
    n_cmp++; if (wr_en !== 1'b0) begin n_err++; $display("FAIL rstpri_wr: got %b want 0", wr_en); end
    n_cmp++; if (occupancy !== 7'd0) begin n_err++; $display("FAIL rstpri_occ: got %0d want 0", occupancy); end
    n_cmp++; if ({err_overflow, err_underflow, err_conflict} !== 3'b000) begin
      n_err++; $display("FAIL rstpri_flags: got %b want 000", {err_overflow, err_underflow, err_conflict}); end
    rst = 1'b0; pulse_in = 1'b0;
    tick();
    n_cmp++; if (wr_en !== 1'b0) begin n_err++; $display("FAIL rstpri_after: got %b want 0", wr_en); end
    release_all();
  endtask

  task automatic test_random();
    int op, hold;
    bit full, empty, ew, er;
    do_reset();
    for (int i = 0; i < 60; i++) begin
      op    = $urandom_range(0, 3);
      full  = (m_occ == DEPTH) || ($urandom_range(0, 5) == 0);
      empty = (m_occ == 0) || ($urandom_range(0, 5) == 0);
      fifo_full = full; fifo_empty = empty;
      ew = (op == 1) && !full && (m_occ < DEPTH);
      er = (op == 2) && !empty && (m_occ > 0);
      if (op == 1 && !ew) m_ovf = 1;
      if (op == 2 && !er) m_udf = 1;
      if (op == 3) m_cnf = 1;
      pulse_in = 1'b1;
      sel_wr = (op == 1 || op == 3);
      sel_rd = (op == 2 || op == 3);
      tick();
      n_cmp++; if ({wr_en, rd_en} !== {ew, er}) begin
        n_err++; $display("FAIL rand_strobe op%0d kind%0d: got %b want %b", i, op, {wr_en, rd_en}, {ew, er}); end
      m_occ = m_occ + int'(ew) - int'(er);
      pulse_in = 1'b0;
      tick();
      n_cmp++; if (occupancy !== 7'(m_occ)) begin
        n_err++; $display("FAIL rand_occ op%0d: got %0d want %0d", i, occupancy, m_occ); end
      n_cmp++; if ({err_overflow, err_underflow, err_conflict} !== {m_ovf, m_udf, m_cnf}) begin
        n_err++; $display("FAIL rand_flags op%0d: got %b want %b", i, {err_overflow, err_underflow, err_conflict}, {m_ovf, m_udf, m_cnf}); end
      hold = $urandom_range(0, 3);
      for (int h = 0; h < hold; h++) begin
        pulse_in = $urandom_range(0, 1);
        tick();
        n_cmp++; if ({wr_en, rd_en} !== 2'b00) begin
          n_err++; $display("FAIL rand_hold op%0d: got %b want 00", i, {wr_en, rd_en}); end
      end
      release_all();
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_idle_no_select();
    test_overflow();
    test_underflow();
    test_conflict();
    test_repeat();
    test_reset_priority();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
